// File: rtl/chi_link_pkg.sv
// Shared CHI link-layer constants, flit types and small helpers used by the
// per-channel receivers of the HN-F.
package chi_link_pkg;

  // Link-layer credit limits.
  localparam int CHI_MAX_LCRD = 15;
  localparam int LCRD_W       = 4;

  // Per-channel flit widths.
  localparam int REQFLIT_W = 121;
  localparam int RSPFLIT_W = 65;
  localparam int DATFLIT_W = 363;

  typedef logic [REQFLIT_W-1:0] req_flit_t;
  typedef logic [RSPFLIT_W-1:0] rsp_flit_t;
  typedef logic [DATFLIT_W-1:0] dat_flit_t;

  // Smaller of two elaboration-time integers.
  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/chi_posq_fifo.sv
// Generic synchronous FIFO holding received flits in arrival order.
// The head is registered storage, so a pushed entry appears one cycle later.
module chi_posq_fifo
  import chi_link_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Advance a pointer, wrapping at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Write the incoming flit at the tail.
  // NOTE: storage has no reset; count gates visibility, so stale data never reaches head.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/hnf_rxchan_posq.sv
// CHI link-layer receive channel: issues L-credits, captures flits into an
// in-order POSQ and flags flits that arrive without a credit.
module hnf_rxchan_posq
  import chi_link_pkg::*;
#(
  parameter int FLIT_W  = 128,
  parameter int DEPTH   = 8,
  parameter int MAX_CRD = CHI_MAX_LCRD
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       link_en,
  input  logic [FLIT_W-1:0]          RXFLIT,
  input  logic                       RXFLITV,
  input  logic                       RXFLITPEND,
  output logic                       RXLCRDV,
  output logic [FLIT_W-1:0]          posq_first_entry,
  output logic                       posq_first_entry_valid,
  input  logic                       posq_first_entry_ready,
  output logic [LCRD_W-1:0]          lcrd_outstanding,
  output logic [$clog2(DEPTH+1)-1:0] posq_count,
  output logic                       link_idle,
  output logic                       proto_err
);

  // Credits in flight plus queued flits may never exceed this ceiling.
  localparam int CAP = min_int(DEPTH, MAX_CRD);

  logic accept;
  logic pop;
  logic grant_next;
  int   committed;

  // The early-valid hint carries no functional meaning for this receiver.
  logic unused_pend;
  assign unused_pend = RXFLITPEND;

  assign accept = RXFLITV && (lcrd_outstanding != '0);
  assign pop    = posq_first_entry_valid && posq_first_entry_ready;

  chi_posq_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .din        (RXFLIT),
    .pop        (pop),
    .head       (posq_first_entry),
    .head_valid (posq_first_entry_valid),
    .count      (posq_count)
  );

  // Decide whether another credit fits, counting the grant already on the wire.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    committed  = 0;
    grant_next = 1'b0;
    committed  = int'(lcrd_outstanding) + int'(posq_count) + int'(RXLCRDV);
    grant_next = link_en && (committed < CAP);
  end

  // Registered credit grant, one credit per asserted cycle.
  always_ff @(posedge clock) begin
    if (reset) RXLCRDV <= 1'b0;
    else       RXLCRDV <= grant_next;
  end

  // Outstanding credits: up on grant, down on a credited arrival.
  always_ff @(posedge clock) begin
    if (reset) begin
      lcrd_outstanding <= '0;
    end else begin
      case ({RXLCRDV, accept})
        2'b10:   lcrd_outstanding <= lcrd_outstanding + LCRD_W'(1);
        2'b01:   lcrd_outstanding <= lcrd_outstanding - LCRD_W'(1);
        default: lcrd_outstanding <= lcrd_outstanding;
      endcase
    end
  end

  // Sticky error: a flit arrived while the sender held no credit.
  always_ff @(posedge clock) begin
    if (reset)                                      proto_err <= 1'b0;
    else if (RXFLITV && (lcrd_outstanding == '0))   proto_err <= 1'b1;
  end

  assign link_idle = (lcrd_outstanding == '0) && (posq_count == '0);

  // Credit accounting must always leave room for every credited flit.
  a_credit_cap : assert property (@(posedge clock) disable iff (reset)
    (int'(lcrd_outstanding) + int'(posq_count)) <= CAP);

endmodule

// File: tb/tb_hnf_rxchan_posq.sv
// Self-checking bench: a directed vector table on a DEPTH=4 receiver plus
// hand-written sequences on a DEPTH=20 receiver for ceiling, reset and wrap.
module tb_hnf_rxchan_posq;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=4 instance
  logic        reset, link_en, flitv, pend, ready;
  logic [15:0] flit;
  logic        lcrdv, valid, idle, err;
  logic [15:0] head;
  logic [3:0]  outst;
  logic [2:0]  cnt;

  // DEPTH=20 instance
  logic        reset_b, link_en_b, flitv_b, pend_b, ready_b;
  logic [15:0] flit_b;
  logic        lcrdv_b, valid_b, idle_b, err_b;
  logic [15:0] head_b;
  logic [3:0]  outst_b;
  logic [4:0]  cnt_b;

  hnf_rxchan_posq #(.FLIT_W(16), .DEPTH(4), .MAX_CRD(15)) u_dut (
    .clock(clock), .reset(reset), .link_en(link_en), .RXFLIT(flit),
    .RXFLITV(flitv), .RXFLITPEND(pend), .RXLCRDV(lcrdv),
    .posq_first_entry(head), .posq_first_entry_valid(valid),
    .posq_first_entry_ready(ready), .lcrd_outstanding(outst),
    .posq_count(cnt), .link_idle(idle), .proto_err(err)
  );

  hnf_rxchan_posq #(.FLIT_W(16), .DEPTH(20), .MAX_CRD(15)) u_dut_b (
    .clock(clock), .reset(reset_b), .link_en(link_en_b), .RXFLIT(flit_b),
    .RXFLITV(flitv_b), .RXFLITPEND(pend_b), .RXLCRDV(lcrdv_b),
    .posq_first_entry(head_b), .posq_first_entry_valid(valid_b),
    .posq_first_entry_ready(ready_b), .lcrd_outstanding(outst_b),
    .posq_count(cnt_b), .link_idle(idle_b), .proto_err(err_b)
  );

  typedef struct {
    logic        rst, en, v;
    logic [15:0] flit;
    logic        rdy;
    logic        e_lcrdv;
    logic [3:0]  e_out;
    logic [2:0]  e_cnt;
    logic        e_valid;
    logic [15:0] e_head;
    logic        e_idle, e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input logic v,
                              input logic [15:0] f, input logic rdy,
                              input logic el, input int eo, input int ec,
                              input logic ev, input logic [15:0] eh,
                              input logic ei, input logic ee);
    vec_t r;
    r.rst = rst; r.en = en; r.v = v; r.flit = f; r.rdy = rdy;
    r.e_lcrdv = el; r.e_out = 4'(eo); r.e_cnt = 3'(ec);
    r.e_valid = ev; r.e_head = eh; r.e_idle = ei; r.e_err = ee;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] exp_head;
    int          max_sum, sum, pops, seq;

    reset = 1'b1; link_en = 1'b0; flitv = 1'b0; pend = 1'b0; ready = 1'b0; flit = '0;
    reset_b = 1'b1; link_en_b = 1'b0; flitv_b = 1'b0; pend_b = 1'b0; ready_b = 1'b0; flit_b = '0;

    //                rst en v  flit     rdy  lcrdv out cnt val head     idle err
    // 1: reset release, credits ramp to CAP=4
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0,   0, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 2, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 3, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   0, 4, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   0, 4, 0, 0, 16'h0000, 0, 0));
    // 2: fill with A..D while stalled, then drain in order
    vecs.push_back(mk(0, 1, 1, 16'hA00A, 0,   0, 3, 1, 1, 16'hA00A, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'hB00B, 0,   0, 2, 2, 1, 16'hA00A, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'hC00C, 0,   0, 1, 3, 1, 16'hA00A, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'hD00D, 0,   0, 0, 4, 1, 16'hA00A, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   0, 0, 4, 1, 16'hA00A, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1,   0, 0, 3, 1, 16'hB00B, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1,   1, 0, 2, 1, 16'hC00C, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1,   1, 1, 1, 1, 16'hD00D, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1,   1, 2, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 3, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   0, 4, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   0, 4, 0, 0, 16'h0000, 0, 0));
    // 3: flit lands in the same cycle as a grant with 3 outstanding
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0,   0, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 2, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 3, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'hE00E, 0,   0, 3, 1, 1, 16'hE00E, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 1,   0, 3, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 3, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   0, 4, 0, 0, 16'h0000, 0, 0));
    // 4: flit with no credit -> dropped, sticky error until reset
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0,   0, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'hF00F, 0,   0, 0, 0, 0, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 0, 0, 0, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 0, 0, 0, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 1, 0, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0,   0, 0, 0, 0, 16'h0000, 1, 0));
    // 5: link_en drops with 2 outstanding; drain, go idle, resume
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 2, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 2, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h1111, 0,   0, 1, 1, 1, 16'h1111, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h2222, 0,   0, 0, 2, 1, 16'h1111, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1,   0, 0, 1, 1, 16'h2222, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1,   0, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 0, 0, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,   1, 1, 0, 0, 16'h0000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset   = vecs[i].rst;
      link_en = vecs[i].en;
      flitv   = vecs[i].v;
      flit    = vecs[i].flit;
      ready   = vecs[i].rdy;
      pend    = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      check($sformatf("v%0d.lcrdv", i), 64'(lcrdv), 64'(vecs[i].e_lcrdv));
      check($sformatf("v%0d.outst", i), 64'(outst), 64'(vecs[i].e_out));
      check($sformatf("v%0d.count", i), 64'(cnt),   64'(vecs[i].e_cnt));
      check($sformatf("v%0d.valid", i), 64'(valid), 64'(vecs[i].e_valid));
      check($sformatf("v%0d.head",  i), 64'(head),  64'(vecs[i].e_head));
      check($sformatf("v%0d.idle",  i), 64'(idle),  64'(vecs[i].e_idle));
      check($sformatf("v%0d.err",   i), 64'(err),   64'(vecs[i].e_err));
    end

    // 6: DEPTH=20 -> ceiling is MAX_CRD=15
    @(negedge clock);
    reset_b = 1'b1; link_en_b = 1'b1;
    @(posedge clock); #1;
    check("b.reset_lcrdv", 64'(lcrdv_b), 64'd0);
    check("b.reset_idle",  64'(idle_b),  64'd1);
    @(negedge clock);
    reset_b = 1'b0;
    max_sum = 0;
    repeat (20) begin
      @(posedge clock); #1;
      sum = int'(outst_b) + int'(cnt_b);
      if (sum > max_sum) max_sum = sum;
    end
    check("b.max_committed", 64'(max_sum), 64'd15);
    check("b.outst_full",    64'(outst_b), 64'd15);
    check("b.lcrdv_stop",    64'(lcrdv_b), 64'd0);

    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      flitv_b = 1'b1;
      flit_b  = 16'h6000 + 16'(k);
    end
    @(negedge clock);
    flitv_b = 1'b0;
    @(posedge clock); #1;
    check("b.count6",  64'(cnt_b),   64'd6);
    check("b.outst9",  64'(outst_b), 64'd9);
    check("b.head6",   64'(head_b),  64'h6000);
    check("b.lcrdv6",  64'(lcrdv_b), 64'd0);

    // Reset with six queued drops everything, no grant in the reset cycle.
    @(negedge clock);
    reset_b = 1'b1;
    @(posedge clock); #1;
    check("b.rst_count", 64'(cnt_b),   64'd0);
    check("b.rst_lcrdv", 64'(lcrdv_b), 64'd0);
    check("b.rst_outst", 64'(outst_b), 64'd0);
    check("b.rst_valid", 64'(valid_b), 64'd0);
    check("b.rst_head",  64'(head_b),  64'd0);
    @(negedge clock);
    reset_b = 1'b0;
    @(posedge clock); #1;
    check("b.first_grant", 64'(lcrdv_b), 64'd1);

    // Streaming with random stalls; order checked against a queue model,
    // enough traffic to wrap the 20-entry pointers several times.
    pops = 0;
    seq  = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      ready_b = ($urandom_range(0, 3) != 0);
      pend_b  = 1'($urandom_range(0, 1));
      if (valid_b && ready_b) begin
        if (exp_q.size() == 0) begin
          check("b.stream_unexpected", 64'(valid_b), 64'd0);
        end else begin
          exp_head = exp_q.pop_front();
          check($sformatf("b.stream%0d", pops), 64'(head_b), 64'(exp_head));
        end
        pops++;
      end
      flitv_b = (outst_b != '0) && ($urandom_range(0, 3) != 0);
      flit_b  = 16'h8000 + 16'(seq);
      if (flitv_b) begin
        exp_q.push_back(flit_b);
        seq++;
      end
    end
    @(negedge clock);
    flitv_b = 1'b0;
    ready_b = 1'b0;
    @(posedge clock); #1;
    check("b.stream_wrapped", 64'(pops >= 45), 64'd1);
    check("b.stream_err",     64'(err_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
